// File: rtl/io_pkg.sv
// Shared constants and types for the memory-mapped I/O responder.
package io_pkg;

  localparam logic [31:0] IN_ADDR_DEF     = 32'h0000_F000;
  localparam logic [31:0] OUT_ADDR_DEF    = 32'h0000_F004;
  localparam logic [31:0] STATUS_ADDR_DEF = 32'h0000_F008;

  localparam int unsigned STAT_RX_AVAIL = 0;
  localparam int unsigned STAT_TX_FULL  = 1;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  function automatic logic [31:0] status_word(input logic tx_full, input logic rx_avail);
    logic [31:0] w;
    w                = '0;
    w[STAT_TX_FULL]  = tx_full;
    w[STAT_RX_AVAIL] = rx_avail;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry an extra wrap bit.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is accepted when a pop frees the head slot on the same edge.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/io_responder.sv
// MEM-stage I/O responder: UART rx bytes -> word FIFO -> loads; stores -> word FIFO -> tx bytes.
module io_responder
  import io_pkg::*;
#(
  parameter int unsigned RX_DEPTH    = 16,
  parameter int unsigned TX_DEPTH    = 16,
  parameter logic [31:0] IN_ADDR     = IN_ADDR_DEF,
  parameter logic [31:0] OUT_ADDR    = OUT_ADDR_DEF,
  parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] in_data,
  output logic        io_stall,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        rx_overrun,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready
);

  logic        rd_in, wr_out, rd_status;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [31:0] rx_word, rx_head;
  logic [1:0]  rx_cnt_q, rx_cnt_d;
  logic [23:0] rx_acc_q, rx_acc_d;
  logic        rx_overrun_q, rx_overrun_d;

  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [31:0] tx_head;
  tx_state_t   state_q;
  logic [31:0] shreg_q;
  logic [1:0]  idx_q;
  logic        tx_valid_q;
  logic [7:0]  tx_byte_q;
  logic [7:0]  next_byte;

  always_comb begin
    rd_in     = req_valid & ~req_we & (req_addr == IN_ADDR);
    rd_status = req_valid & ~req_we & (req_addr == STATUS_ADDR);
    wr_out    = req_valid &  req_we & (req_addr == OUT_ADDR);
    io_stall  = (rd_in & rx_empty) | (wr_out & tx_full);
    rx_pop    = rd_in & ~rx_empty;
    tx_push   = wr_out & ~tx_full;
    tx_pop    = (state_q == TX_IDLE) & ~tx_empty;
  end

  always_comb begin
    in_data = '0;
    if (rd_in && !rx_empty) in_data = rx_head;
    else if (rd_status)     in_data = status_word(tx_full, ~rx_empty);
  end

  // The fourth byte is never stored in the accumulator; it goes straight into the pushed word.
  always_comb begin
    rx_cnt_d = rx_cnt_q;
    rx_acc_d = rx_acc_q;
    rx_push  = 1'b0;
    rx_word  = {rx_byte, rx_acc_q};
    if (rx_valid) begin
      rx_cnt_d = rx_cnt_q + 2'd1;
      case (rx_cnt_q)
        2'd0:    rx_acc_d[7:0]   = rx_byte;
        2'd1:    rx_acc_d[15:8]  = rx_byte;
        2'd2:    rx_acc_d[23:16] = rx_byte;
        default: rx_push         = 1'b1;
      endcase
    end
    rx_overrun_d = rx_overrun_q | (rx_push & rx_full & ~rx_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt_q     <= '0;
      rx_acc_q     <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_cnt_q     <= rx_cnt_d;
      rx_acc_q     <= rx_acc_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  sync_fifo #(.WIDTH(32), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_word),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (req_wdata),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_comb begin
    case (idx_q)
      2'd0:    next_byte = shreg_q[15:8];
      2'd1:    next_byte = shreg_q[23:16];
      default: next_byte = shreg_q[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      shreg_q    <= '0;
      idx_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (!tx_empty) begin
            shreg_q    <= tx_head;
            idx_q      <= '0;
            tx_valid_q <= 1'b1;
            tx_byte_q  <= tx_head[7:0];
            state_q    <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_ready) begin
            if (idx_q == 2'd3) begin
              tx_valid_q <= 1'b0;
              tx_byte_q  <= '0;
              state_q    <= TX_IDLE;
            end else begin
              idx_q     <= idx_q + 2'd1;
              tx_byte_q <= next_byte;
            end
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign rx_overrun = rx_overrun_q;
  assign tx_valid   = tx_valid_q;
  assign tx_byte    = tx_byte_q;

endmodule

// File: tb/tb_io_responder.sv
// Directed scoreboard bench for io_responder: rx words and tx bytes checked against queues.
module tb_io_responder;

  localparam logic [31:0] IN_A   = 32'h0000_F000;
  localparam logic [31:0] OUT_A  = 32'h0000_F004;
  localparam logic [31:0] STAT_A = 32'h0000_F008;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] in_data;
  logic        io_stall;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic        rx_overrun;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int tx_sent = 0;
  logic [31:0] rx_q[$];
  logic [7:0]  tx_q[$];
  logic        held_v = 1'b0;
  logic [7:0]  held_b = '0;

  io_responder #(
    .RX_DEPTH    (16),
    .TX_DEPTH    (16),
    .IN_ADDR     (IN_A),
    .OUT_ADDR    (OUT_A),
    .STATUS_ADDR (STAT_A)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .in_data    (in_data),
    .io_stall   (io_stall),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_overrun (rx_overrun),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit stored);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    if (stored) rx_q.push_back(w);
  endtask

  task automatic load_in(input string tag);
    logic [31:0] exp;
    req_valid = 1'b1; req_we = 1'b0; req_addr = IN_A;
    @(negedge clk);
    exp = (rx_q.size() > 0) ? rx_q.pop_front() : 32'hBAD0_BAD0;
    check({tag, "_stall"}, {31'b0, io_stall}, 32'd0);
    check({tag, "_data"}, in_data, exp);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic load_status(input string tag, input logic [31:0] exp);
    req_valid = 1'b1; req_we = 1'b0; req_addr = STAT_A;
    @(negedge clk);
    check(tag, in_data, exp);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic store(input logic [31:0] w, output int stalls);
    stalls = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = OUT_A; req_wdata = w;
    @(negedge clk);
    while (io_stall && stalls < 300) begin
      stalls++;
      @(negedge clk);
    end
    check("store_accept", {31'b0, io_stall}, 32'd0);
    if (!io_stall) for (int k = 0; k < 4; k++) tx_q.push_back(w[8*k +: 8]);
    tick();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic wait_tx_drain();
    for (int c = 0; c < 1000 && (tx_q.size() != 0 || tx_valid); c++) tick();
    check("tx_drain", tx_q.size(), 32'd0);
  endtask

  // Transmit-side monitor: each accepted byte must match the head of the expected-byte queue.
  always @(negedge clk) begin
    if (!rst && tx_valid) begin
      if (held_v) check("tx_hold", {24'b0, tx_byte}, {24'b0, held_b});
      if (tx_ready) begin
        if (tx_q.size() == 0) check("tx_unexpected", {24'b0, tx_byte}, 32'hFFFF_FFFF);
        else check("tx_byte", {24'b0, tx_byte}, {24'b0, tx_q.pop_front()});
        tx_sent++;
        held_v = 1'b0;
      end else begin
        held_v = 1'b1;
        held_b = tx_byte;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    int st;
    int base;
    logic [31:0] w;

    // reset values
    tick();
    @(negedge clk);
    check("rst_in_data", in_data, 32'd0);
    check("rst_stall", {31'b0, io_stall}, 32'd0);
    check("rst_overrun", {31'b0, rx_overrun}, 32'd0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_tx_byte", {24'b0, tx_byte}, 32'd0);
    tick();
    rst = 1'b0;
    load_status("rst_status", 32'h0000_0000);

    // basic rx assembly
    send_word(32'h4433_2211, 1'b1);
    load_status("status_rx_avail", 32'h0000_0001);
    load_in("rx_basic");
    load_status("status_after_pop", 32'h0000_0000);

    // load waits on empty rx FIFO while bytes arrive
    w = 32'hA4A3_A2A1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = IN_A;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("in_wait_stall", {31'b0, io_stall}, 32'd1);
      rx_byte = w[8*k +: 8];
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    rx_q.push_back(w);
    @(negedge clk);
    check("in_wait_release", {31'b0, io_stall}, 32'd0);
    check("in_wait_data", in_data, rx_q.pop_front());
    tick();
    req_valid = 1'b0;

    // unmapped address has no effect
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_F00C;
    @(negedge clk);
    check("unmapped_data", in_data, 32'd0);
    check("unmapped_stall", {31'b0, io_stall}, 32'd0);
    tick();
    req_valid = 1'b0;

    // tx byte order, then a stall mid-word
    tx_ready = 1'b1;
    store(32'hDEAD_BEEF, st);
    wait_tx_drain();
    base = tx_sent;
    store(32'h0403_0201, st);
    for (int c = 0; c < 100 && tx_sent < base + 2; c++) @(negedge clk);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    repeat (4) tick();
    tx_ready = 1'b1;
    wait_tx_drain();

    // fill tx path with ready low: first word goes to the shifter, 16 more fill the FIFO
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      store(32'hC000_0000 + i, st);
      check("tx_fill_nostall", st, 32'd0);
    end
    load_status("status_tx_full", 32'h0000_0002);
    w = 32'h5A5A_0011;
    req_valid = 1'b1; req_we = 1'b1; req_addr = OUT_A; req_wdata = w;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("tx_full_stall", {31'b0, io_stall}, 32'd1);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 50 && io_stall; c++) @(negedge clk);
    check("tx_full_accept", {31'b0, io_stall}, 32'd0);
    if (!io_stall) for (int k = 0; k < 4; k++) tx_q.push_back(w[8*k +: 8]);
    tick();
    req_valid = 1'b0; req_we = 1'b0;
    wait_tx_drain();

    // rx overrun: 17 words, only 16 retained
    for (int i = 0; i < 17; i++) begin
      if (i == 16) check("overrun_before", {31'b0, rx_overrun}, 32'd0);
      send_word(32'h1000_0000 + i * 32'h0001_0101, i < 16);
    end
    @(negedge clk);
    check("overrun_set", {31'b0, rx_overrun}, 32'd1);
    tick();
    for (int i = 0; i < 16; i++) load_in("overrun_read");
    load_status("overrun_empty", 32'h0000_0000);
    check("overrun_sticky", {31'b0, rx_overrun}, 32'd1);

    // reset with a partial rx word and a tx word in flight
    tx_ready = 1'b0;
    send_byte(8'h99);
    send_byte(8'h98);
    store(32'h0A0B_0C0D, st);
    repeat (3) tick();
    check("pre_rst_tx_valid", {31'b0, tx_valid}, 32'd1);
    rst = 1'b1;
    tx_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("mid_rst_tx_byte", {24'b0, tx_byte}, 32'd0);
    check("mid_rst_overrun", {31'b0, rx_overrun}, 32'd0);
    check("mid_rst_stall", {31'b0, io_stall}, 32'd0);
    check("mid_rst_in_data", in_data, 32'd0);
    tick();
    tx_ready = 1'b1;
    repeat (8) tick();
    check("post_rst_tx_idle", {31'b0, tx_valid}, 32'd0);
    load_status("post_rst_status", 32'h0000_0000);
    send_word(32'h8877_6655, 1'b1);
    load_in("post_rst_word");

    check("rx_sb_empty", rx_q.size(), 32'd0);
    check("tx_sb_empty", tx_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
